uart_stim_tx: RTL and testbench

//  Byte-oriented UART transmitter (8N1) with input FIFO; drives the SoC i_uart_rx pin.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_tx_fifo.sv | 72 +++++++
 rtl/uart_stim_tx.sv | 157 +++++++++++++++
 tb/tb_uart_stim_tx.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART stimulus transmitter: FSM state
// encodings and the bit-period helper used at elaboration time.
package uart_pkg;

  // FSM state encodings
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  // Bits per character on the line: start + 8 data + stop
  localparam int FRAME_BITS = 10;

  // Core clocks per line bit; truncating division so the line runs
  // slightly fast rather than slow when the ratio is not integral.
  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO feeding the UART transmitter. First-word-fall-through:
// rd_data always shows the oldest entry while the FIFO is non-empty.
// Pointers carry one extra wrap bit so full/empty come from a plain
// compare and wrap-around needs no special handling.
module uart_tx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [AW:0]      r_level;
  logic             w_push;
  logic             w_pop;

  // Full when the index bits match but the wrap bits differ
  assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                 (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign empty = (r_wr_ptr == r_rd_ptr);

  // A write while full or a read while empty is silently ignored
  assign w_push = wr_en && !full;
  assign w_pop  = rd_en && !empty;

  assign rd_data = r_mem[r_rd_ptr[AW-1:0]];
  assign level   = r_level;

  // Storage array; contents are don't-care until written, so no reset
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
    end
  end

  // Pointer advance on accepted push/pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Registered occupancy; simultaneous push and pop leaves it unchanged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_level <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/uart_stim_tx.sv
// Byte-oriented 8N1 UART transmitter with an input FIFO. Used by the sim
// top and FPGA wrapper to drive console input into the SoC receive pin.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | line high; pops the FIFO head as soon as it is non-empty
//   START | start bit (low) for one bit period
//   DATA  | 8 data bits, LSB first, one bit period each
//   STOP  | stop bit (high); at its end pops the next byte or idles
//
// Every state entry restarts the baud counter at 0, so each frame is
// exactly FRAME_BITS bit periods and back-to-back frames have no gap.
module uart_stim_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int BAUD        = 115200,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    i_data,
  input  logic                          i_valid,
  output logic                          o_ready,
  output logic                          o_tx,
  output logic                          o_busy,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUD);
  localparam int BW           = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);
  localparam int LW           = $clog2(FIFO_DEPTH) + 1;

  // Reject parameter sets the counters and FIFO pointers cannot support
  if (CLKS_PER_BIT < 2) begin : g_bad_baud
    $error("uart_stim_tx: CLKS_PER_BIT must be >= 2 (got %0d)", CLKS_PER_BIT);
  end
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("uart_stim_tx: FIFO_DEPTH must be a power of 2 >= 2 (got %0d)", FIFO_DEPTH);
  end

  logic [1:0]    r_state;
  logic [BW-1:0] r_baud_cnt;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic          r_tx;

  logic          w_fifo_full;
  logic          w_fifo_empty;
  logic [7:0]    w_fifo_rd_data;
  logic [LW-1:0] w_fifo_level;
  logic          w_push;
  logic          w_pop;
  logic          w_baud_tc;

  // Ready reflects occupancy before the edge; a same-edge pop never
  // opens a slot for a push when the FIFO is full.
  assign o_ready = !w_fifo_full;
  assign w_push  = i_valid && !w_fifo_full;

  assign w_baud_tc = (r_baud_cnt == BW'(CLKS_PER_BIT - 1));

  // Pop from IDLE immediately, or at the end of a stop bit to chain frames
  assign w_pop = !w_fifo_empty &&
                 ((r_state == ST_IDLE) || ((r_state == ST_STOP) && w_baud_tc));

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (w_push),
    .wr_data (i_data),
    .rd_en   (w_pop),
    .rd_data (w_fifo_rd_data),
    .full    (w_fifo_full),
    .empty   (w_fifo_empty),
    .level   (w_fifo_level)
  );

  // Frame sequencing: state, bit timing, shift register and line flop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_baud_cnt <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_tx       <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_baud_cnt <= '0;
          r_tx       <= 1'b1;
          if (!w_fifo_empty) begin
            r_state <= ST_START;
            r_shift <= w_fifo_rd_data;
            r_tx    <= 1'b0;
          end
        end

        ST_START: begin
          if (w_baud_tc) begin
            r_state    <= ST_DATA;
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_tx       <= r_shift[0];
          end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
          end
        end

        ST_DATA: begin
          if (w_baud_tc) begin
            r_baud_cnt <= '0;
            if (r_bit_idx == 3'd7) begin
              r_state <= ST_STOP;
              r_tx    <= 1'b1;
            end else begin
              r_bit_idx <= r_bit_idx + 1'b1;
              r_shift   <= {1'b0, r_shift[7:1]};
              r_tx      <= r_shift[1];
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
          end
        end

        ST_STOP: begin
          if (w_baud_tc) begin
            r_baud_cnt <= '0;
            if (!w_fifo_empty) begin
              r_state <= ST_START;
              r_shift <= w_fifo_rd_data;
              r_tx    <= 1'b0;
            end else begin
              r_state <= ST_IDLE;
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
          end
        end

        default: begin
          r_state    <= ST_IDLE;
          r_baud_cnt <= '0;
          r_tx       <= 1'b1;
        end
      endcase
    end
  end

  assign o_tx         = r_tx;
  assign o_busy       = (r_state != ST_IDLE) || !w_fifo_empty;
  assign o_fifo_level = w_fifo_level;

endmodule

// File: tb/tb_uart_stim_tx.sv
// Directed and scoreboarded bench for uart_stim_tx at 4 clocks per bit
// with a 4-entry FIFO. A line decoder on o_tx records each 40-cycle frame.
module tb_uart_stim_tx;

  localparam int CLK_FREQ_HZ = 1000;
  localparam int BAUD        = 250;
  localparam int FIFO_DEPTH  = 4;
  localparam int LW          = $clog2(FIFO_DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [7:0]    i_data;
  logic          i_valid;
  logic          o_ready;
  logic          o_tx;
  logic          o_busy;
  logic [LW-1:0] o_fifo_level;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  bit mon_en = 1'b0;

  logic [7:0] q_rx[$];
  logic       q_ok[$];
  int         q_start[$];
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  uart_stim_tx #(
    .CLK_FREQ_HZ (CLK_FREQ_HZ),
    .BAUD        (BAUD),
    .FIFO_DEPTH  (FIFO_DEPTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_data       (i_data),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .o_tx         (o_tx),
    .o_busy       (o_busy),
    .o_fifo_level (o_fifo_level)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    q_rx.delete();
    q_ok.delete();
    q_start.delete();
  endtask

  task automatic wait_frames(input int n, input int bound, input string tag);
    int k;
    k = 0;
    while (q_rx.size() < n && k < bound) begin
      tick();
      k++;
    end
    chk(tag, q_rx.size(), n);
  endtask

  task automatic wait_idle(input int bound, input string tag);
    int k;
    k = 0;
    while (o_busy !== 1'b0 && k < bound) begin
      tick();
      k++;
    end
    chk(tag, o_busy, 0);
  endtask

  // Line decoder: a low level starts a 40-sample capture; every bit must be
  // stable for 4 samples, start low, stop high, data sampled mid-bit.
  initial begin
    int         cnt;
    bit         act;
    int         st;
    logic [39:0] s;
    logic       ok;
    logic [7:0] b;
    act = 1'b0;
    cnt = 0;
    st  = 0;
    s   = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!mon_en) begin
        act = 1'b0;
      end else if (!act) begin
        if (o_tx === 1'b0) begin
          act = 1'b1;
          cnt = 1;
          s   = '0;
          st  = cyc;
        end
      end else begin
        s[cnt] = o_tx;
        cnt++;
        if (cnt == 40) begin
          ok = 1'b1;
          for (int k = 0; k < 10; k++)
            for (int j = 0; j < 4; j++)
              if (s[4*k+j] !== s[4*k+2]) ok = 1'b0;
          if (s[2] !== 1'b0 || s[38] !== 1'b1) ok = 1'b0;
          for (int i = 0; i < 8; i++) b[i] = s[4*i+6];
          q_rx.push_back(b);
          q_ok.push_back(ok);
          q_start.push_back(st);
          act = 1'b0;
        end
      end
    end
  end

  initial begin
    logic [7:0] b55;
    logic       exp_bit;
    int         lows;
    int         busys;

    rst_n   = 1'b1;
    i_valid = 1'b0;
    i_data  = 8'h00;
    #2 rst_n = 1'b0;
    #20;
    chk("rst_tx",    o_tx, 1);
    chk("rst_ready", o_ready, 1);
    chk("rst_busy",  o_busy, 0);
    chk("rst_level", o_fifo_level, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) tick();
    chk("idle_tx", o_tx, 1);
    mon_en = 1'b1;

    // 1: single byte 0x55, cycle-exact line waveform
    clear_mon();
    b55 = 8'h55;
    i_data = b55; i_valid = 1'b1;
    tick();                                   // edge A
    i_valid = 1'b0;
    chk("t1_level_A", o_fifo_level, 1);
    chk("t1_tx_A",    o_tx, 1);
    chk("t1_busy_A",  o_busy, 1);
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (c <= 4)       exp_bit = 1'b0;
      else if (c <= 36) exp_bit = b55[(c-5)/4];
      else              exp_bit = 1'b1;
      chk($sformatf("t1_tx_A+%0d", c), o_tx, exp_bit);
      if (c == 1) chk("t1_level_A+1", o_fifo_level, 0);
    end
    chk("t1_busy_A+40", o_busy, 1);
    tick();
    chk("t1_busy_A+41", o_busy, 0);
    chk("t1_tx_A+41",   o_tx, 1);
    wait_frames(1, 20, "t1_frames");
    if (q_rx.size() >= 1) begin
      chk("t1_byte", q_rx[0], 8'h55);
      chk("t1_ok",   q_ok[0], 1);
    end

    // 2: two bytes on consecutive cycles, frames back to back
    repeat (5) tick();
    clear_mon();
    i_data = 8'hA3; i_valid = 1'b1;
    tick();
    i_data = 8'h0F;
    tick();
    i_valid = 1'b0;
    chk("t2_level", o_fifo_level, 1);
    wait_frames(2, 150, "t2_frames");
    if (q_rx.size() >= 2) begin
      chk("t2_byte0", q_rx[0], 8'hA3);
      chk("t2_byte1", q_rx[1], 8'h0F);
      chk("t2_ok0",   q_ok[0], 1);
      chk("t2_ok1",   q_ok[1], 1);
      chk("t2_gap",   q_start[1] - q_start[0], 40);
    end
    wait_idle(20, "t2_idle");

    // 3 + 5: source holds i_valid for 0x01..0x06; full FIFO stalls 0x06,
    // which is refused on the pop edge and accepted the cycle after
    repeat (5) tick();
    clear_mon();
    i_valid = 1'b1;
    i_data = 8'h01; tick();                   // A
    chk("t3_level_A", o_fifo_level, 1);
    i_data = 8'h02; tick();                   // A+1
    chk("t3_tx_A+1",    o_tx, 0);
    chk("t3_level_A+1", o_fifo_level, 1);
    i_data = 8'h03; tick();
    i_data = 8'h04; tick();
    i_data = 8'h05; tick();                   // A+4
    chk("t3_level_A+4", o_fifo_level, 4);
    chk("t3_ready_A+4", o_ready, 0);
    i_data = 8'h06;
    repeat (36) tick();                       // A+40
    chk("t5_level_A+40", o_fifo_level, 4);
    chk("t5_ready_A+40", o_ready, 0);
    tick();                                   // A+41: pop, push refused
    chk("t5_level_A+41", o_fifo_level, 3);
    chk("t5_ready_A+41", o_ready, 1);
    tick();                                   // A+42: held byte accepted
    chk("t5_level_A+42", o_fifo_level, 4);
    i_valid = 1'b0;
    wait_frames(6, 400, "t3_frames");
    wait_idle(60, "t3_idle");
    repeat (10) tick();
    chk("t3_count", q_rx.size(), 6);
    for (int k = 0; k < 6; k++) begin
      if (k < q_rx.size()) begin
        chk($sformatf("t3_byte%0d", k), q_rx[k], k + 1);
        chk($sformatf("t3_ok%0d", k), q_ok[k], 1);
      end
    end

    // 4: async reset mid-DATA of 0xFF with two bytes queued
    repeat (5) tick();
    clear_mon();
    i_valid = 1'b1;
    i_data = 8'hFF; tick();                   // A
    i_data = 8'h11; tick();
    i_data = 8'h22; tick();                   // A+2
    i_valid = 1'b0;
    chk("t4_level_A+2", o_fifo_level, 2);
    repeat (8) tick();                        // A+10, inside DATA
    chk("t4_tx_data", o_tx, 1);
    chk("t4_busy",    o_busy, 1);
    mon_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("t4_rst_tx",    o_tx, 1);
    chk("t4_rst_level", o_fifo_level, 0);
    chk("t4_rst_ready", o_ready, 1);
    chk("t4_rst_busy",  o_busy, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    lows = 0;
    busys = 0;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (o_tx !== 1'b1) lows++;
      if (o_busy !== 1'b0) busys++;
    end
    chk("t4_post_lows",  lows, 0);
    chk("t4_post_busy",  busys, 0);
    chk("t4_post_level", o_fifo_level, 0);
    clear_mon();
    mon_en = 1'b1;

    // 6: 200 random bytes with random gaps, scoreboard through the decoder
    repeat (3) tick();
    exp_q.delete();
    for (int i = 0; i < 200; i++) begin
      int         gap;
      int         w;
      logic [7:0] d;
      gap = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 60) : $urandom_range(0, 2);
      i_valid = 1'b0;
      repeat (gap) tick();
      d = 8'($urandom_range(0, 255));
      i_data  = d;
      i_valid = 1'b1;
      w = 0;
      while (o_ready !== 1'b1 && w < 500) begin
        tick();
        w++;
      end
      chk($sformatf("t6_src_wait%0d", i), (w < 500), 1);
      tick();
      exp_q.push_back(d);
    end
    i_valid = 1'b0;
    wait_frames(200, 2000, "t6_frames");
    wait_idle(100, "t6_idle");
    repeat (10) tick();
    chk("t6_count", q_rx.size(), 200);
    for (int k = 0; k < 200; k++) begin
      if (k < q_rx.size()) begin
        chk($sformatf("t6_byte%0d", k), q_rx[k], exp_q[k]);
        chk($sformatf("t6_frame%0d", k), q_ok[k], 1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
